// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM burst arbiter: FSM state encoding and
// a slice extractor for the packed per-requester base/length buses.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rom_arb_state_t;

    localparam int SLICE_BUS_W = 1024;
    localparam int SLICE_W     = 32;

    // Field idx of width w from a packed bus; callers zero-extend the bus and truncate the result.
    function automatic logic [SLICE_W-1:0] req_slice(input logic [SLICE_BUS_W-1:0] bus,
                                                     input int idx, input int w);
        return SLICE_W'(bus >> (idx * w)) & ({SLICE_W{1'b1}} >> (SLICE_W - w));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester at or above ptr.
// Zero latency; no backpressure, grant is empty when nothing requests.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int idx;

    // Walk from the farthest candidate back to ptr so the closest requester is written last.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (((req >> idx) & N'(1)) != '0) begin
                gnt = N'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one 1-cycle-latency ROM among NUM_REQ burst requesters; gnt at T+1, data T+2..T+1+len.
// No backpressure: requesters hold req until they see their gnt bit; bursts run to completion.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [ADDR_WIDTH-1:0]          rom_addr,
    input  logic [DATA_WIDTH-1:0]          rom_q,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REQ-1:0]             rd_valid,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rom_arb_state_t        state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d, win_q, win_d, arb_idx;
    logic [NUM_REQ-1:0]    arb_gnt, win_oh;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d, rd_valid_q, rd_valid_d, done_q, done_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, sel_len;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d, sel_base;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req),
        .ptr (rr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt == (NUM_REQ'(1) << i)) begin
                arb_idx = IW'(i);
            end
        end
    end

    assign sel_base = ADDR_WIDTH'(req_slice(SLICE_BUS_W'(req_base), int'(arb_idx), ADDR_WIDTH));
    assign sel_len  = LEN_WIDTH'(req_slice(SLICE_BUS_W'(req_len), int'(arb_idx), LEN_WIDTH));
    assign win_oh   = NUM_REQ'(1) << win_q;

    // cnt counts addresses already presented; in a zero-length DRAIN it provides the extra wait cycle.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        win_d      = win_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        gnt_d      = '0;
        rd_valid_d = '0;
        done_d     = '0;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    win_d = arb_idx;
                    len_d = sel_len;
                    gnt_d = arb_gnt;
                    if (sel_len == '0) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d    = ISSUE;
                        rom_addr_d = sel_base;
                        cnt_d      = LEN_WIDTH'(1);
                    end
                end
            end
            ISSUE: begin
                rd_valid_d = win_oh;
                if (cnt_q == len_q) begin
                    state_d = DRAIN;
                    done_d  = win_oh;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                    cnt_d      = cnt_q + LEN_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (done_q != '0) begin
                    state_d = IDLE;
                    rr_d    = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
                end else if (cnt_q != '0) begin
                    done_d = win_oh;
                end else begin
                    cnt_d = LEN_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            win_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            win_q      <= win_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    assign gnt      = gnt_q;
    assign rom_addr = rom_addr_q;
    assign rd_data  = rom_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: ROM model mem[a]=a[7:0], a cycle-level reference model built
// from the burst timing rules, a table of directed bursts and hand-written corner sequences.
module tb_rom_burst_arbiter;

    localparam int NR = 2;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk, rst_n;
    logic [NR-1:0] req;
    logic [AW-1:0] b0, b1;
    logic [LW-1:0] l0, l1;
    logic [NR-1:0] gnt, rd_valid, done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q, rd_data;
    logic          busy;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total, bad, cyc;

    typedef struct {
        logic [1:0]  req;
        logic [9:0]  b0, l0, b1, l1;
        logic [1:0]  gnt;
        int          beats;
        logic [7:0]  first, last;
        int          dly;
    } vec_t;

    vec_t vt [9];

    rom_burst_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_base ({b1, b0}),
        .req_len  ({l1, l0}),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'(a);
    end

    always @(posedge clk) rom_q <= mem[rom_addr];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: expected outputs per cycle number, scheduled whole-burst at decision time.
    int m_gnt [int];
    int m_rv  [int];
    int m_done[int];
    int m_addr[int];
    int m_dat [int];
    int m_idle_from, m_busy_from, m_ptr, m_last_addr;

    task automatic model_clear();
        m_gnt.delete(); m_rv.delete(); m_done.delete(); m_addr.delete(); m_dat.delete();
        m_idle_from = 0; m_busy_from = 0; m_ptr = 0; m_last_addr = 0;
    endtask

    task automatic model_decide(input int t);
        int w, len, base, c;
        if (t < m_idle_from || req == '0) return;
        w = -1;
        for (int i = 0; i < NR; i++) begin
            c = (m_ptr + i) % NR;
            if (w < 0 && ((int'(req) >> c) & 1) == 1) w = c;
        end
        base = (w == 0) ? int'(b0) : int'(b1);
        len  = (w == 0) ? int'(l0) : int'(l1);
        m_gnt[t+1] = 1 << w;
        for (int k = 0; k < len; k++) begin
            m_addr[t+1+k] = (base + k) % 1024;
            m_rv[t+2+k]   = 1 << w;
            m_dat[t+2+k]  = (base + k) % 256;
        end
        m_done[(len == 0) ? t + 3 : t + 1 + len] = 1 << w;
        m_busy_from = t + 1;
        m_idle_from = (len == 0) ? t + 4 : t + 2 + len;
        m_ptr = (w + 1) % NR;
    endtask

    initial begin
        cyc = 0;
        model_clear();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) model_clear();
            else        model_decide(cyc - 1);
            chk("gnt",      int'(gnt),      m_gnt.exists(cyc)  ? m_gnt[cyc]  : 0);
            chk("rd_valid", int'(rd_valid), m_rv.exists(cyc)   ? m_rv[cyc]   : 0);
            chk("done",     int'(done),     m_done.exists(cyc) ? m_done[cyc] : 0);
            chk("busy",     int'(busy),     (cyc >= m_busy_from && cyc < m_idle_from) ? 1 : 0);
            if (m_addr.exists(cyc)) m_last_addr = m_addr[cyc];
            chk("rom_addr", int'(rom_addr), m_last_addr);
            if (m_rv.exists(cyc)) chk("rd_data", int'(rd_data), m_dat[cyc]);
        end
    end

    task automatic wait_gnt(output logic [1:0] g, output bit seen);
        g = '0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                g = gnt;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [1:0] g;
        bit         seen;
        int         beats, dly;
        logic [7:0] first, last;
        req = v.req; b0 = v.b0; l0 = v.l0; b1 = v.b1; l1 = v.l1;
        wait_gnt(g, seen);
        chk($sformatf("v%0d_gnt", id), int'(g), int'(v.gnt));
        req = '0;
        if (seen) begin
            beats = 0; dly = -1; first = '0; last = '0;
            for (int k = 1; k <= 2000 && dly < 0; k++) begin
                @(negedge clk);
                if (rd_valid != '0) begin
                    if (beats == 0) first = rd_data;
                    last = rd_data;
                    beats++;
                end
                if (done != '0) dly = k;
            end
            chk($sformatf("v%0d_beats", id), beats, v.beats);
            chk($sformatf("v%0d_done_dly", id), dly, v.dly);
            if (v.beats > 0) begin
                chk($sformatf("v%0d_first", id), int'(first), int'(v.first));
                chk($sformatf("v%0d_last", id), int'(last), int'(v.last));
            end
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", id), int'(busy), 0);
        end
    endtask

    initial begin
        logic [1:0] g;
        bit         seen;
        int         beats, ng, nd, quiet;
        int         gs [4];
        int         exp_gs [4];

        total = 0; bad = 0;
        rst_n = 1'b0; req = '0; b0 = '0; b1 = '0; l0 = '0; l1 = '0;
        exp_gs[0] = 2; exp_gs[1] = 1; exp_gs[2] = 2; exp_gs[3] = 1;

        //          req    b0      l0      b1      l1      gnt    beats first  last   dly
        vt[0] = '{2'b01, 10'h010, 10'd4, 10'h000, 10'd0, 2'b01, 4,    8'h10, 8'h13, 4};
        vt[1] = '{2'b01, 10'h3FE, 10'd4, 10'h000, 10'd0, 2'b01, 4,    8'hFE, 8'h01, 4};
        vt[2] = '{2'b11, 10'h100, 10'd2, 10'h200, 10'd3, 2'b10, 3,    8'h00, 8'h02, 3};
        vt[3] = '{2'b11, 10'h123, 10'd1, 10'h055, 10'd5, 2'b01, 1,    8'h23, 8'h23, 1};
        vt[4] = '{2'b10, 10'h000, 10'd0, 10'h0AA, 10'd0, 2'b10, 0,    8'h00, 8'h00, 2};
        vt[5] = '{2'b10, 10'h000, 10'd0, 10'h2F0, 10'd2, 2'b10, 2,    8'hF0, 8'hF1, 2};
        vt[6] = '{2'b01, 10'h3FF, 10'd1, 10'h000, 10'd0, 2'b01, 1,    8'hFF, 8'hFF, 1};
        vt[7] = '{2'b01, 10'h000, 10'h3FF, 10'h000, 10'd0, 2'b01, 1023, 8'h00, 8'hFE, 1023};
        vt[8] = '{2'b01, 10'h1A5, 10'd1, 10'h000, 10'd0, 2'b01, 1,    8'hA5, 8'hA5, 1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Request dropped and base/len changed mid-burst: data must follow the latched base.
        req = 2'b01; b0 = 10'h040; l0 = 10'd8;
        wait_gnt(g, seen);
        chk("mid_gnt", int'(g), 1);
        req = '0; b0 = 10'h300; l0 = 10'd3;
        beats = 0;
        for (int k = 0; k < 40 && seen; k++) begin
            @(negedge clk);
            if (rd_valid != '0) begin
                chk($sformatf("mid_d%0d", beats), int'(rd_data), (8'h40 + beats) % 256);
                beats++;
            end
            if (done != '0) seen = 1'b0;
        end
        chk("mid_beats", beats, 8);
        @(negedge clk);

        // Contention: both held for four bursts; pointer currently favours requester 1.
        req = 2'b11; b0 = 10'h000; l0 = 10'd2; b1 = 10'h050; l1 = 10'd2;
        ng = 0; nd = 0;
        for (int k = 0; k < 100 && nd < 4; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (ng < 4) gs[ng] = int'(gnt);
                ng++;
                chk("cont_onehot", $countones(gnt), 1);
                if (ng == 4) req = '0;
            end
            if (done != '0) nd++;
        end
        repeat (4) begin
            @(negedge clk);
            if (gnt != '0) ng++;
        end
        chk("cont_ngnt", ng, 4);
        chk("cont_ndone", nd, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), gs[i], exp_gs[i]);

        // Reset after three of eight words: everything clears at once, no done afterwards.
        req = 2'b01; b0 = 10'h080; l0 = 10'd8;
        wait_gnt(g, seen);
        chk("rst_pre_gnt", int'(g), 1);
        req = '0;
        beats = 0;
        for (int k = 0; k < 40 && beats < 3; k++) begin
            @(negedge clk);
            if (rd_valid != '0) beats++;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0 || rd_valid != '0) quiet++;
        end
        chk("rst_quiet", quiet, 0);
        rst_n = 1'b1;
        run_vec(vt[8], 8);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                req = 2'($urandom_range(0, 3));
                b0  = 10'($urandom);
                b1  = 10'($urandom);
                l0  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(10, 40)) : 10'($urandom_range(0, 5));
                l1  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(10, 40)) : 10'($urandom_range(0, 5));
            end
        end
        req = '0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("final_idle", int'(seen && !busy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
